branch_predictor: RTL and testbench



---
 rtl/branch_predictor_if.sv | 29 ++
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Pipeline <-> branch predictor signal bundle: IF-stage lookup, EX-stage resolution,
// and the statistics counters. The pipeline side is the master, the predictor the slave.
interface branch_predictor_if #(
  parameter int NBITS    = 32,
  parameter int CNT_BITS = 16
);
  logic [NBITS-1:0]    PC_IF;
  logic                PredTaken_IF;
  logic [NBITS-1:0]    PredTarget_IF;
  logic                Resolve_EX;
  logic [NBITS-1:0]    PC_EX;
  logic [NBITS-1:0]    BranchTarget_EX;
  logic                Taken_EX;
  logic                PredTaken_EX;
  logic                Mispredict;
  logic [NBITS-1:0]    RedirectPC;
  logic [CNT_BITS-1:0] BranchCount;
  logic [CNT_BITS-1:0] MissCount;

  modport master (
    output PC_IF, Resolve_EX, PC_EX, BranchTarget_EX, Taken_EX, PredTaken_EX,
    input  PredTaken_IF, PredTarget_IF, Mispredict, RedirectPC, BranchCount, MissCount
  );

  modport slave (
    input  PC_IF, Resolve_EX, PC_EX, BranchTarget_EX, Taken_EX, PredTaken_EX,
    output PredTaken_IF, PredTarget_IF, Mispredict, RedirectPC, BranchCount, MissCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tag/target store, same-cycle
// misprediction flush/redirect at EX, and saturating branch/miss statistics.
module branch_predictor #(
  parameter int NBITS      = 32,
  parameter int INDEX_BITS = 4,
  parameter int CNT_BITS   = 16
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bus
);
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = NBITS - INDEX_BITS - 2;

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [NBITS-1:0]    target;
    logic [1:0]          ctr;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};

  entry_t              table_q [ENTRIES];
  logic [CNT_BITS-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_BITS-1:0] miss_cnt_q, miss_cnt_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  entry_t                if_entry, ex_entry, entry_d;
  logic                  if_hit, ex_hit, we_d;
  logic                  resolve_act, mispredict;
  logic                  unused_pc_bits;

  assign if_idx   = bus.PC_IF[INDEX_BITS+1:2];
  assign if_tag   = bus.PC_IF[NBITS-1:INDEX_BITS+2];
  assign ex_idx   = bus.PC_EX[INDEX_BITS+1:2];
  assign ex_tag   = bus.PC_EX[NBITS-1:INDEX_BITS+2];
  assign if_entry = table_q[if_idx];
  assign ex_entry = table_q[ex_idx];
  assign if_hit   = if_entry.valid && (if_entry.tag == if_tag);
  assign ex_hit   = ex_entry.valid && (ex_entry.tag == ex_tag);

  assign unused_pc_bits = ^{bus.PC_IF[1:0], bus.PC_EX[1:0]};

  // Reset suppresses every externally visible effect of a resolve in the same cycle.
  assign resolve_act = bus.Resolve_EX && !reset;
  assign mispredict  = resolve_act && (bus.Taken_EX ^ bus.PredTaken_EX);

  assign bus.Mispredict  = mispredict;
  assign bus.RedirectPC  = !resolve_act ? '0 :
                           bus.Taken_EX ? bus.BranchTarget_EX : bus.PC_EX + NBITS'(4);
  assign bus.BranchCount = branch_cnt_q;
  assign bus.MissCount   = miss_cnt_q;

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    bus.PredTaken_IF  = 1'b0;
    bus.PredTarget_IF = '0;
    if (if_hit && !reset) begin
      bus.PredTaken_IF  = if_entry.ctr[1];
      bus.PredTarget_IF = if_entry.target;
    end
  end

  always_comb begin
    we_d    = 1'b0;
    entry_d = ex_entry;
    if (resolve_act) begin
      if (ex_hit) begin
        we_d           = 1'b1;
        entry_d.target = bus.BranchTarget_EX;
        if (bus.Taken_EX) begin
          if (ex_entry.ctr != CTR_STRONG_T) entry_d.ctr = ex_entry.ctr + 2'b01;
        end else begin
          if (ex_entry.ctr != CTR_STRONG_NT) entry_d.ctr = ex_entry.ctr - 2'b01;
        end
      end else if (bus.Taken_EX) begin
        // Miss on a taken branch: allocate, evicting whatever shared the index.
        we_d    = 1'b1;
        entry_d = '{valid: 1'b1, tag: ex_tag, target: bus.BranchTarget_EX, ctr: CTR_WEAK_T};
      end
    end
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (resolve_act && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + CNT_BITS'(1);
    if (mispredict && (miss_cnt_q != '1))    miss_cnt_d   = miss_cnt_q + CNT_BITS'(1);
  end

  // NOTE: sequential state is written only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the table is built from flops rather than RAM, so it can and must be
      // cleared by reset; otherwise stale valid bits would produce phantom hits.
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= RESET_ENTRY;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (we_d) table_q[ex_idx] <= entry_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus a randomized run
// compared against an array-based reference model of the predictor.
module tb_branch_predictor;
  localparam int unsigned CNT_MAX = 65535;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  branch_predictor_if #(.NBITS(32), .CNT_BITS(16)) bus ();
  branch_predictor_if #(.NBITS(32), .CNT_BITS(4))  bus4 ();

  branch_predictor #(.NBITS(32), .INDEX_BITS(4), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  branch_predictor #(.NBITS(32), .INDEX_BITS(4), .CNT_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave)
  );

  // Reference model: 16 entries indexed by word address mod 16, tag = PC / 64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  int unsigned m_bc, m_mc;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = '0; m_cnt[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic void model_lookup(input logic [31:0] pc, output bit taken,
                                       output logic [31:0] tgt);
    int idx = int'((pc / 4) % 16);
    taken = 0; tgt = '0;
    if (m_valid[idx] && m_tag[idx] == pc / 64) begin
      taken = (m_cnt[idx] >= 2); tgt = m_tgt[idx];
    end
  endfunction

  function automatic void model_resolve(input logic [31:0] pc, input logic [31:0] tgt,
                                        input bit taken, input bit pred);
    int idx = int'((pc / 4) % 16);
    bit hit = m_valid[idx] && (m_tag[idx] == pc / 64);
    if (m_bc < CNT_MAX) m_bc++;
    if (taken != pred && m_mc < CNT_MAX) m_mc++;
    if (hit) begin
      m_tgt[idx] = tgt;
      m_cnt[idx] = taken ? ((m_cnt[idx] < 3) ? m_cnt[idx] + 1 : 3)
                         : ((m_cnt[idx] > 0) ? m_cnt[idx] - 1 : 0);
    end else if (taken) begin
      m_valid[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tgt; m_cnt[idx] = 2;
    end
  endfunction

  // Advance one edge, mirror the edge into the model, then settle off the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else if (bus.Resolve_EX)
      model_resolve(bus.PC_EX, bus.BranchTarget_EX, bus.Taken_EX, bus.PredTaken_EX);
    #1;
  endtask

  task automatic drive_resolve(input bit res, input logic [31:0] pc, input logic [31:0] tgt,
                               input bit taken, input bit pred);
    bus.Resolve_EX = res; bus.PC_EX = pc; bus.BranchTarget_EX = tgt;
    bus.Taken_EX = taken; bus.PredTaken_EX = pred;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.PC_IF = 32'h0040_0010;
    drive_resolve(1, 32'h0040_0010, 32'h0040_0040, 1, 0);
    @(negedge clk);
    n_checks++; if (bus.Mispredict !== 1'b0) begin n_fail++;
      $display("FAIL reset_mispredict: got %0b want 0", bus.Mispredict); end
    n_checks++; if (bus.RedirectPC !== 32'h0) begin n_fail++;
      $display("FAIL reset_redirect: got %h want 0", bus.RedirectPC); end
    n_checks++; if (bus.PredTaken_IF !== 1'b0) begin n_fail++;
      $display("FAIL reset_pred: got %0b want 0", bus.PredTaken_IF); end
    tick();
    reset = 1'b0;
    drive_resolve(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    n_checks++; if (bus.PredTaken_IF !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_pred: got %0b want 0", bus.PredTaken_IF); end
    n_checks++; if (bus.BranchCount !== 16'd0 || bus.MissCount !== 16'd0) begin n_fail++;
      $display("FAIL post_reset_counts: got %0d/%0d want 0/0", bus.BranchCount, bus.MissCount); end
    n_checks++; if (bus.Mispredict !== 1'b0) begin n_fail++;
      $display("FAIL post_reset_mispredict: got %0b want 0", bus.Mispredict); end
    tick();
  endtask

  // Cold taken branch, with PC_IF == PC_EX to cover same-cycle lookup vs update.
  task automatic test_cold_taken();
    bus.PC_IF = 32'h0040_0010;
    drive_resolve(1, 32'h0040_0010, 32'h0040_0040, 1, 0);
    @(negedge clk);
    n_checks++; if (bus.Mispredict !== 1'b1) begin n_fail++;
      $display("FAIL cold_mispredict: got %0b want 1", bus.Mispredict); end
    n_checks++; if (bus.RedirectPC !== 32'h0040_0040) begin n_fail++;
      $display("FAIL cold_redirect: got %h want 00400040", bus.RedirectPC); end
    n_checks++; if (bus.PredTaken_IF !== 1'b0) begin n_fail++;
      $display("FAIL same_cycle_pred: got %0b want 0", bus.PredTaken_IF); end
    tick();
    drive_resolve(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    n_checks++; if (bus.PredTaken_IF !== 1'b1 || bus.PredTarget_IF !== 32'h0040_0040) begin
      n_fail++; $display("FAIL cold_next_pred: got %0b/%h want 1/00400040",
                         bus.PredTaken_IF, bus.PredTarget_IF); end
    n_checks++; if (bus.BranchCount !== 16'd1 || bus.MissCount !== 16'd1) begin n_fail++;
      $display("FAIL cold_counts: got %0d/%0d want 1/1", bus.BranchCount, bus.MissCount); end
    tick();
  endtask

  task automatic test_saturation();
    bus.PC_IF = 32'h0040_0010;
    for (int i = 0; i < 3; i++) begin
      drive_resolve(1, 32'h0040_0010, 32'h0040_0040, 1, 1);
      @(negedge clk);
      n_checks++; if (bus.Mispredict !== 1'b0) begin n_fail++;
        $display("FAIL sat_taken_%0d: mispredict got %0b want 0", i, bus.Mispredict); end
      tick();
    end
    drive_resolve(1, 32'h0040_0010, 32'h0040_0040, 0, 1);
    @(negedge clk);
    n_checks++; if (bus.Mispredict !== 1'b1 || bus.RedirectPC !== 32'h0040_0014) begin
      n_fail++; $display("FAIL hyst_nt1: got %0b/%h want 1/00400014",
                         bus.Mispredict, bus.RedirectPC); end
    tick();
    @(negedge clk);
    n_checks++; if (bus.PredTaken_IF !== 1'b1) begin n_fail++;
      $display("FAIL hyst_still_taken: got %0b want 1", bus.PredTaken_IF); end
    tick();
    drive_resolve(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    n_checks++; if (bus.PredTaken_IF !== 1'b0) begin n_fail++;
      $display("FAIL hyst_flipped: got %0b want 0", bus.PredTaken_IF); end
    n_checks++; if (bus.BranchCount !== 16'd6 || bus.MissCount !== 16'd3) begin n_fail++;
      $display("FAIL sat_counts: got %0d/%0d want 6/3", bus.BranchCount, bus.MissCount); end
    tick();
  endtask

  task automatic test_aliasing();
    bus.PC_IF = 32'h0040_0010;
    drive_resolve(1, 32'h0040_0050, 32'h0040_0100, 1, 0);
    tick();
    drive_resolve(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    n_checks++; if (bus.PredTaken_IF !== 1'b0) begin n_fail++;
      $display("FAIL alias_evicted: got %0b want 0", bus.PredTaken_IF); end
    tick();
    bus.PC_IF = 32'h0040_0050;
    @(negedge clk);
    n_checks++; if (bus.PredTaken_IF !== 1'b1 || bus.PredTarget_IF !== 32'h0040_0100) begin
      n_fail++; $display("FAIL alias_new: got %0b/%h want 1/00400100",
                         bus.PredTaken_IF, bus.PredTarget_IF); end
    tick();
  endtask

  task automatic test_reset_mid_resolve();
    reset = 1'b1;
    drive_resolve(1, 32'h0040_0050, 32'h0040_0200, 1, 0);
    @(negedge clk);
    n_checks++; if (bus.Mispredict !== 1'b0 || bus.RedirectPC !== 32'h0) begin n_fail++;
      $display("FAIL reset_resolve_flush: got %0b/%h want 0/0", bus.Mispredict, bus.RedirectPC); end
    tick();
    reset = 1'b0;
    drive_resolve(0, 32'h0, 32'h0, 0, 0);
    bus.PC_IF = 32'h0040_0050;
    @(negedge clk);
    n_checks++; if (bus.PredTaken_IF !== 1'b0) begin n_fail++;
      $display("FAIL reset_resolve_table: got %0b want 0", bus.PredTaken_IF); end
    n_checks++; if (bus.BranchCount !== 16'd0 || bus.MissCount !== 16'd0) begin n_fail++;
      $display("FAIL reset_resolve_counts: got %0d/%0d want 0/0", bus.BranchCount, bus.MissCount); end
    tick();
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h0040_0000 | (32'($urandom_range(0, 31)) << 2) | (32'($urandom_range(0, 1)) << 12);
  endfunction

  task automatic test_random();
    bit          exp_pt, ex_pred, taken, res, exp_mp;
    logic [31:0] exp_tgt, dummy, pc_ex, tgt, exp_redir;
    for (int i = 0; i < 400; i++) begin
      bus.PC_IF = rand_pc();
      pc_ex = rand_pc();
      tgt   = 32'h0040_0000 | (32'($urandom_range(0, 4095)) << 2);
      res   = ($urandom_range(0, 9) < 7);
      taken = $urandom_range(0, 1);
      model_lookup(pc_ex, ex_pred, dummy);
      if ($urandom_range(0, 3) == 0) ex_pred = $urandom_range(0, 1);
      drive_resolve(res, pc_ex, tgt, taken, ex_pred);
      model_lookup(bus.PC_IF, exp_pt, exp_tgt);
      exp_mp    = res && (taken != ex_pred);
      exp_redir = !res ? 32'h0 : (taken ? tgt : pc_ex + 32'd4);
      @(negedge clk);
      n_checks++; if (bus.PredTaken_IF !== exp_pt || bus.PredTarget_IF !== exp_tgt) begin
        n_fail++; $display("FAIL rand_pred[%0d]: got %0b/%h want %0b/%h", i,
                           bus.PredTaken_IF, bus.PredTarget_IF, exp_pt, exp_tgt); end
      n_checks++; if (bus.Mispredict !== exp_mp || bus.RedirectPC !== exp_redir) begin
        n_fail++; $display("FAIL rand_resolve[%0d]: got %0b/%h want %0b/%h", i,
                           bus.Mispredict, bus.RedirectPC, exp_mp, exp_redir); end
      n_checks++; if (bus.BranchCount !== 16'(m_bc) || bus.MissCount !== 16'(m_mc)) begin
        n_fail++; $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d", i,
                           bus.BranchCount, bus.MissCount, m_bc, m_mc); end
      tick();
    end
    drive_resolve(0, 32'h0, 32'h0, 0, 0);
  endtask

  // Narrow counters: 20 mispredicting resolves must stick at 15, not wrap.
  task automatic test_count_saturation();
    bus4.Resolve_EX = 1'b1; bus4.PC_EX = 32'h0040_0020; bus4.BranchTarget_EX = 32'h0040_0080;
    bus4.Taken_EX = 1'b1; bus4.PredTaken_EX = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (bus4.BranchCount !== 4'((i < 15) ? i : 15)) begin n_fail++;
        $display("FAIL sat4_progress[%0d]: got %0d want %0d", i, bus4.BranchCount,
                 (i < 15) ? i : 15); end
      tick();
    end
    bus4.Resolve_EX = 1'b0;
    @(negedge clk);
    n_checks++; if (bus4.BranchCount !== 4'd15 || bus4.MissCount !== 4'd15) begin n_fail++;
      $display("FAIL sat4_final: got %0d/%0d want 15/15", bus4.BranchCount, bus4.MissCount); end
    tick();
    @(negedge clk);
    n_checks++; if (bus4.BranchCount !== 4'd15) begin n_fail++;
      $display("FAIL sat4_hold: got %0d want 15", bus4.BranchCount); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    reset = 1'b1;
    bus.PC_IF = '0;
    drive_resolve(0, 32'h0, 32'h0, 0, 0);
    bus4.PC_IF = '0; bus4.Resolve_EX = 1'b0; bus4.PC_EX = '0;
    bus4.BranchTarget_EX = '0; bus4.Taken_EX = 1'b0; bus4.PredTaken_EX = 1'b0;
    #1;
    test_reset();
    test_cold_taken();
    test_saturation();
    test_aliasing();
    test_reset_mid_resolve();
    test_random();
    test_count_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
